// File: rtl/img_stream_packer_pkg.sv
// img_stream_pkg: shared state encoding, Fletcher modulus and byte-swap helper for the image packer
package img_stream_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PIXELS, CKSUM0, CKSUM1, PAD, FINISH} state_t;
  localparam logic [15:0] FLETCHER_MOD = 16'hFFFF;
  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction
endpackage

// File: rtl/img_stream_packer_if.sv
// img_stream_packer_if: valid/ready word stream used for both the pixel input and the packed output
interface img_stream_packer_if #(parameter int W = 16);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/img_stream_packer_fletcher32_accum.sv
// fletcher32_accum: running Fletcher-32 sums, each reduced mod 65535 with one conditional subtract
module fletcher32_accum
  import img_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [31:0] sum
);
  logic [15:0] s1, s2, n1, n2;
  logic [16:0] a1, a2;
  always_comb begin
    a1 = {1'b0, s1} + {1'b0, din};
    n1 = a1 >= {1'b0, FLETCHER_MOD} ? 16'(a1 - {1'b0, FLETCHER_MOD}) : a1[15:0];
    a2 = {1'b0, s2} + {1'b0, n1};
    n2 = a2 >= {1'b0, FLETCHER_MOD} ? 16'(a2 - {1'b0, FLETCHER_MOD}) : a2[15:0];
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1 <= '0;
      s2 <= '0;
    end else if (en) begin
      s1 <= n1;
      s2 <= n2;
    end
  end
  assign sum = {s2, s1};
endmodule

// File: rtl/img_stream_packer.sv
// img_stream_packer: emits header, byte-swapped pixels, optional Fletcher-32 and zero padding as a 16-bit stream
module img_stream_packer
  import img_stream_pkg::*;
#(
  parameter int HeaderWordCount  = 4,
  parameter int ChecksumEn       = 1,
  parameter int PaddingWordCount = 0,
  parameter int PixelCountWidth  = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PixelCountWidth-1:0]    pixel_count,
  input  logic [16*HeaderWordCount-1:0] hdr,
  img_stream_packer_if.slave            pix,
  img_stream_packer_if.master           out,
  output logic                          busy,
  output logic                          done
);
  localparam int MaxIdx = HeaderWordCount > PaddingWordCount ? HeaderWordCount : PaddingWordCount;
  localparam int IW = MaxIdx > 1 ? $clog2(MaxIdx) : 1;
  localparam logic [IW-1:0] HLAST = IW'(HeaderWordCount - 1);
  localparam logic [IW-1:0] PLAST = IW'(PaddingWordCount > 0 ? PaddingWordCount - 1 : 0);
  localparam state_t AFTER_CK = PaddingWordCount > 0 ? PAD : FINISH;
  localparam state_t AFTER_PIX = ChecksumEn != 0 ? CKSUM0 : AFTER_CK;

  state_t                     state, state_n;
  logic [IW-1:0]              idx;
  logic [PixelCountWidth-1:0] cnt, pcnt;
  logic                       free, load, acc, idx_inc, idx_clr, pix_take, fin, accept;
  logic [15:0]                word;
  logic [31:0]                sum;

  assign free      = !out.valid || out.ready;
  assign accept    = state == IDLE && start;
  assign pix.ready = state == PIXELS && free;
  assign pix_take  = pix.ready && pix.valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    acc     = 1'b0;
    word    = '0;
    idx_inc = 1'b0;
    idx_clr = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: state_n = start ? HEADER : IDLE;
      HEADER: if (free) begin
        load    = 1'b1;
        acc     = 1'b1;
        word    = hdr[16*idx +: 16];
        idx_inc = idx != HLAST;
        idx_clr = idx == HLAST;
        state_n = idx != HLAST ? HEADER : cnt == '0 ? AFTER_PIX : PIXELS;
      end
      PIXELS: if (pix_take) begin
        load    = 1'b1;
        acc     = 1'b1;
        word    = bswap16(pix.data);
        state_n = pcnt == cnt - 1'b1 ? AFTER_PIX : PIXELS;
      end
      CKSUM0: if (free) begin
        load    = 1'b1;
        word    = bswap16(sum[15:0]);
        state_n = CKSUM1;
      end
      CKSUM1: if (free) begin
        load    = 1'b1;
        word    = bswap16(sum[31:16]);
        state_n = AFTER_CK;
      end
      PAD: if (free) begin
        load    = 1'b1;
        idx_inc = idx != PLAST;
        idx_clr = idx == PLAST;
        state_n = idx == PLAST ? FINISH : PAD;
      end
      FINISH: if (free) begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.valid <= 1'b0;
      out.data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      pcnt      <= '0;
      cnt       <= '0;
    end else begin
      done <= fin;
      if (accept) begin
        cnt  <= pixel_count;
        busy <= 1'b1;
        idx  <= '0;
        pcnt <= '0;
      end
      if (fin) busy <= 1'b0;
      if (idx_clr) idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (pix_take) pcnt <= pcnt + 1'b1;
      // a free slot either takes the next word or goes empty; a stalled word is held untouched
      if (free) begin
        out.valid <= load;
        if (load) out.data <= word;
      end
    end
  end

  fletcher32_accum u_acc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (load && acc),
    .din (bswap16(word)),
    .sum (sum)
  );
endmodule

// File: tb/tb_img_stream_packer.sv
// tb_img_stream_packer: randomized checks of two packer configurations against a queue-based stream model
module tb_img_stream_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0, st = 1'b0, pv = 1'b0, ordy = 1'b0;
  logic [15:0] pd = '0, hdr_a = '0;
  logic [31:0] hdr_b = '0;
  logic [23:0] pc = '0;
  logic        busy_a, busy_b, done_a, done_b, st_a, st_b;
  logic        ov, prdy, busy, done;
  logic [15:0] od;
  int          total = 0, bad = 0;
  logic [15:0] exp_q[$], got[$], pix_q[$];

  always #5 clk = ~clk;

  img_stream_packer_if pa(), oa(), pb(), ob();
  assign st_a     = !sel && st;
  assign st_b     = sel && st;
  assign pa.valid = !sel && pv;
  assign pb.valid = sel && pv;
  assign pa.data  = pd;
  assign pb.data  = pd;
  assign oa.ready = ordy;
  assign ob.ready = ordy;
  assign ov   = sel ? ob.valid : oa.valid;
  assign od   = sel ? ob.data : oa.data;
  assign prdy = sel ? pb.ready : pa.ready;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;

  img_stream_packer #(.HeaderWordCount(1), .ChecksumEn(1), .PaddingWordCount(0), .PixelCountWidth(24)) dut_a (
    .clk(clk), .rst(rst), .start(st_a), .pixel_count(pc), .hdr(hdr_a),
    .pix(pa), .out(oa), .busy(busy_a), .done(done_a));
  img_stream_packer #(.HeaderWordCount(2), .ChecksumEn(1), .PaddingWordCount(3), .PixelCountWidth(24)) dut_b (
    .clk(clk), .rst(rst), .start(st_b), .pixel_count(pc), .hdr(hdr_b),
    .pix(pb), .out(ob), .busy(busy_b), .done(done_b));

  // Stream model: header as given, pixels swapped, Fletcher-32 over the host-order values, zero padding
  task automatic build_expected(input bit b, input int n);
    int s1 = 0, s2 = 0, nh = b ? 2 : 1, np = b ? 3 : 0;
    logic [15:0] w;
    exp_q.delete();
    for (int h = 0; h < nh; h++) begin
      w = b ? hdr_b[16*h +: 16] : hdr_a;
      exp_q.push_back(w);
      s1 = (s1 + int'({w[7:0], w[15:8]})) % 65535;
      s2 = (s2 + s1) % 65535;
    end
    for (int i = 0; i < n; i++) begin
      w = pix_q[i];
      exp_q.push_back({w[7:0], w[15:8]});
      s1 = (s1 + int'(w)) % 65535;
      s2 = (s2 + s1) % 65535;
    end
    exp_q.push_back({s1[7:0], s1[15:8]});
    exp_q.push_back({s2[7:0], s2[15:8]});
    for (int i = 0; i < np; i++) exp_q.push_back(16'h0000);
  endtask

  task automatic run_image(input bit b, input int n, input int rmode, input int vmode, input bit restart);
    int cyc = 0, pi = 0, last = -10, dones = 0;
    bit stall = 0, fin = 0, saw_prdy = 0;
    logic [15:0] pod = '0;
    int nexp;
    sel = b;
    build_expected(b, n);
    nexp = exp_q.size();
    got.delete();
    @(posedge clk); #1;
    st = 1'b1; pc = 24'(n); pv = 1'b0; ordy = rmode != 1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy); end
      end
      if (stall) begin
        total++;
        if (ov !== 1'b1 || od !== pod) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, ov, od, pod);
        end
      end
      if (ov && ordy) begin
        got.push_back(od);
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_word got=%h want=none", od);
        end else begin
          if (od !== exp_q[0]) begin bad++; $display("FAIL word%0d got=%h want=%h", got.size()-1, od, exp_q[0]); end
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) last = cyc;
        end
      end
      if (prdy) saw_prdy = 1;
      if (pv && prdy) pi++;
      if (done) begin
        dones++;
        total++;
        if (cyc != last + 1 || busy !== 1'b0) begin
          bad++; $display("FAIL done_timing cyc=%0d busy=%b want cyc=%0d busy=0", cyc, busy, last + 1);
        end
      end
      stall = ov && !ordy;
      pod = od;
      if (dones > 0 && cyc >= last + 4) fin = 1;
      @(posedge clk); #1;
      cyc++;
      st = restart && cyc == 2;
      pc = 24'($urandom);
      ordy = rmode == 0 ? 1'b1 : rmode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      pv = pi < n && (vmode == 0 || (vmode == 1 && cyc >= 4) || (vmode == 2 && $urandom_range(0, 3) != 0));
      pd = pi < n ? pix_q[pi] : 16'($urandom);
    end
    st = 1'b0; pv = 1'b0;
    total++;
    if (!fin) begin bad++; $display("FAIL timeout words=%0d want=%0d", got.size(), nexp); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL done_count got=%0d want=1", dones); end
    total++;
    if (got.size() != nexp) begin bad++; $display("FAIL word_count got=%0d want=%0d", got.size(), nexp); end
    if (n == 0) begin
      total++;
      if (saw_prdy) begin bad++; $display("FAIL pix_ready_zero got=1 want=0"); end
    end
  endtask

  task automatic check_known(input string tag);
    logic [15:0] k[4] = '{16'h0102, 16'h0300, 16'h0402, 16'h0504};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got.size() || got[i] !== k[i]) begin
        bad++; $display("FAIL %s_w%0d got=%h want=%h", tag, i, i < got.size() ? got[i] : 16'hxxxx, k[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({oa.valid, oa.data, pa.ready, busy_a, done_a} !== 20'h0 ||
        {ob.valid, ob.data, pb.ready, busy_b, done_b} !== 20'h0) begin
      bad++; $display("FAIL reset_state got=%b%h%b%b%b / %b%h%b%b%b want=all zero",
        oa.valid, oa.data, pa.ready, busy_a, done_a, ob.valid, ob.data, pb.ready, busy_b, done_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_known();
    hdr_a = 16'h0102;
    pix_q = '{16'h0003};
    run_image(0, 1, 0, 0, 0);
    check_known("known");
  endtask

  task automatic test_stall();
    hdr_a = 16'h0102;
    pix_q = '{16'h0003};
    run_image(0, 1, 1, 1, 0);
    check_known("stall");
  endtask

  task automatic test_zero_pixels();
    logic [15:0] k[7] = '{16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    hdr_b = {16'hBBBB, 16'hAAAA};
    pix_q.delete();
    run_image(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 3) continue;
      total++;
      if (i >= got.size() || got[i] !== k[i]) begin
        bad++; $display("FAIL zero_w%0d got=%h want=%h", i, i < got.size() ? got[i] : 16'hxxxx, k[i]);
      end
    end
  endtask

  task automatic test_wrap();
    hdr_a = 16'hFFFF;
    pix_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_image(0, 4, 2, 0, 0);
    for (int i = 5; i < 7; i++) begin
      total++;
      if (i >= got.size() || got[i] !== 16'h0000) begin
        bad++; $display("FAIL wrap_w%0d got=%h want=0000", i, i < got.size() ? got[i] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0, cyc = 0;
    sel = 1'b0;
    hdr_a = 16'h0102;
    pix_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    @(posedge clk); #1;
    st = 1'b1; pc = 24'd5; ordy = 1'b1; pv = 1'b1; pd = pix_q[0];
    while (acc < 2 && cyc < 50) begin
      @(negedge clk);
      if (pa.valid && pa.ready) acc++;
      @(posedge clk); #1;
      st = 1'b0; cyc++;
      pd = pix_q[acc];
    end
    total++;
    if (acc < 2) begin bad++; $display("FAIL mid_accept got=%0d want=2", acc); end
    rst = 1'b1; pv = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (oa.valid !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%b want=0/0", oa.valid, busy_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pix_q = '{16'h0003};
    run_image(0, 1, 0, 0, 0);
    check_known("rerun");
  endtask

  task automatic test_restart();
    hdr_b = 32'h1234_5678;
    pix_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    run_image(1, 3, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(0, 12);
      bit b = 1'($urandom_range(0, 1));
      hdr_a = 16'($urandom);
      hdr_b = $urandom;
      pix_q.delete();
      for (int i = 0; i < n; i++) pix_q.push_back(16'($urandom));
      run_image(b, n, 2, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_stall();
    test_zero_pixels();
    test_wrap();
    test_reset_mid();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/img_stream_packer.md
Name: img_stream_packer

Overview:
Synthesizable transmit side of the image word stream that the sim-side pixel checker consumes. On `start`, emits 16-bit words in a fixed order: header words, pixel words taken from upstream, an optional Fletcher-32 checksum (2 words), then padding words. Sits between the pixel source (sensor capture or RAM readout) and the SD write path.

Parameters:
HeaderWordCount, 4, number of 16-bit header words (≥1).
ChecksumEn, 1, 1 = append the 2 checksum words; 0 = no checksum.
PaddingWordCount, 0, number of padding words after the checksum; each padding word = 16'h0000.
PixelCountWidth, 24, width of the runtime pixel count.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins an image; ignored unless idle
pixel_count  in  PixelCountWidth  pixels in the image; sampled when start is accepted
hdr  in  16*HeaderWordCount  header; word i = hdr[16*i+:16] = {byte 2i, byte 2i+1}; held stable while busy
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  pixel accepted when pix_valid & pix_ready
pix_data  in  16  pixel value in host order
out_valid  out  1  output word valid
out_ready  in  1  downstream ready
out_data  out  16  output word
busy  out  1  high from start acceptance until the final word transfers
done  out  1  one-cycle pulse on the cycle after the final word transfers

Behaviour:
- Reset: state IDLE; out_valid=0, out_data=0, pix_ready=0, busy=0, done=0; checksum accumulators cleared.
- Output register: out_valid/out_data are registered. A slot is free when !out_valid or out_ready. In a free slot, load the next word or drop out_valid. Sustained rate is 1 word/clk when out_ready=1. out_data is stable while out_valid & !out_ready.
- States:
  - IDLE: on start, latch pixel_count, clear sums, set busy, go to HEADER.
  - HEADER: emit hdr words 0..HeaderWordCount-1 unmodified. Then go to PIXELS, or to CKSUM0/PAD/FINISH if pixel_count=0.
  - PIXELS: pix_ready = free slot. An accepted pixel is emitted as out_data = {pix_data[7:0], pix_data[15:8]} (little-endian). Leave after pixel_count accepts. Stall if !pix_valid (out_valid drops).
  - CKSUM0 / CKSUM1: only if ChecksumEn. With chk = {sum2, sum1}, emit w0 = {chk[7:0], chk[15:8]}, then w1 = {chk[23:16], chk[31:24]}.
  - PAD: emit PaddingWordCount zero words.
  - FINISH: when the last word transfers, clear busy, pulse done, return to IDLE.
  - Skip any empty section.
- Checksum:
  - Every header and pixel word is byte-swapped (d = {w[7:0], w[15:8]}) before accumulation, at the moment it is loaded into the output register.
  - sum1 = (sum1 + d) mod 65535, then sum2 = (sum2 + sum1_new) mod 65535.
  - Each mod uses a 17-bit add and one conditional subtract of 65535. A sum equal to 65535 becomes 0.
  - Padding and checksum words are not accumulated.
- Boundaries:
  - start while busy is ignored.
  - rst mid-image returns to IDLE immediately and discards the partial stream, including any pending out_valid.
  - pixel_count is wrapped modulo 2^PixelCountWidth. A count of 0 is legal.
  - The pixel counter compares against the latched count.
  - The word after the last pixel may be loaded in the same cycle the last pixel transfers (no bubble).

Decomposition:
- Package img_stream_pkg:
  - state enum (IDLE, HEADER, PIXELS, CKSUM0, CKSUM1, PAD, FINISH)
  - constant FLETCHER_MOD = 16'hFFFF
  - function bswap16
- Sub-module fletcher32_accum (clk, rst, clr, en, din[15:0], sum[31:0]): the mod-65535 accumulator, reusable elsewhere.

Test Plan:
- HeaderWordCount=1, hdr=16'h0102, pixel_count=1, pix_data=16'h0003, ChecksumEn=1, PaddingWordCount=0, out_ready=1 -> words 0102, 0300, 0402, 0504; done pulses 1 clk later; busy low after.
- Same config, out_ready toggled every other cycle and pix_valid delayed 3 clks -> identical word sequence, no duplicates or drops, out_data stable while stalled.
- pixel_count=0, HeaderWordCount=2, hdr={16'hBBBB, 16'hAAAA}, PaddingWordCount=3 -> AAAA, BBBB, checksum words, 0000 ×3; pix_ready never asserts.
- 4 pixels of 16'hFFFF, header 16'hFFFF -> sums stay 0 (mod wrap); checksum words 0000, 0000.
- rst asserted after 2 pixels, then new start with pixel_count=1 -> fresh header and checksum identical to a first-run result; no stale words.
- start pulsed again while busy -> ignored; exactly one done pulse per image.
